ram_access_ctrl: RTL and testbench

Request/response front-end that sits directly upstream of a dual-read-port, single-write-port RAM array (16-bit words) and owns its write and read address buses. It accepts read and write requests from a client over a valid/ready handshake and sequences them onto the RAM pins. Read data returns on a held valid/ready response channel. It also sweeps the whole array to a fill value after reset and on demand, so clients never see uninitialised contents.

---
 rtl/ram_access_ctrl_pkg.sv | 25 ++
 rtl/ram_access_ctrl_sweep_counter.sv | 25 ++
 rtl/ram_access_ctrl.sv | 114 +++++++++++
 tb/tb_ram_access_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_access_ctrl_pkg.sv
// Shared constants for the RAM access front-end: FSM encoding and the
// default geometry used by the RAM blocks.
package ram_access_ctrl_pkg;

  localparam int          ADDR_W_DEF     = 16;
  localparam int          DATA_W_DEF     = 16;
  localparam logic [15:0] FILL_VALUE_DEF = 16'h0000;

  localparam logic [2:0] ST_RST_WAIT = 3'd0;
  localparam logic [2:0] ST_CLEAR    = 3'd1;
  localparam logic [2:0] ST_IDLE     = 3'd2;
  localparam logic [2:0] ST_WRITE    = 3'd3;
  localparam logic [2:0] ST_READ     = 3'd4;
  localparam logic [2:0] ST_RESP     = 3'd5;

  typedef enum logic [2:0] {
    RST_WAIT = ST_RST_WAIT,
    CLEAR    = ST_CLEAR,
    IDLE     = ST_IDLE,
    WRITE    = ST_WRITE,
    READ     = ST_READ,
    RESP     = ST_RESP
  } state_e;

endpackage

// File: rtl/ram_access_ctrl_sweep_counter.sv
// Address counter for the clear sweep; o_last flags the final address so
// the sweep can stop without a carry-out bit.
module ram_sweep_counter #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  output logic [ADDR_W-1:0] o_count,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_count <= '0;
    else if (i_clr) r_count <= '0;
    else if (i_en)  r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;
  assign o_last  = &r_count;

endmodule

// File: rtl/ram_access_ctrl.sv
// Valid/ready front-end for a 2R1W RAM: sequences client reads/writes onto
// the RAM pins and sweeps the array to FILL_VALUE after reset or on request.
module ram_access_ctrl
  import ram_access_ctrl_pkg::*;
#(
  parameter int                ADDR_W     = ADDR_W_DEF,
  parameter int                DATA_W     = DATA_W_DEF,
  parameter logic [DATA_W-1:0] FILL_VALUE = DATA_W'(FILL_VALUE_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr_a,
  input  logic [ADDR_W-1:0] req_addr_b,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data_a,
  output logic [DATA_W-1:0] rsp_data_b,
  input  logic              clr_req,
  output logic              busy,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_d_in,
  output logic [ADDR_W-1:0] ram_rd_addr_a,
  output logic [ADDR_W-1:0] ram_rd_addr_b,
  input  logic [DATA_W-1:0] ram_d_out_a,
  input  logic [DATA_W-1:0] ram_d_out_b
);

  state_e            r_state, w_next;
  logic [ADDR_W-1:0] w_count;
  logic              w_last;
  logic              w_accept;
  logic [ADDR_W-1:0] r_wr_addr, r_rd_addr_a, r_rd_addr_b;
  logic [DATA_W-1:0] r_wdata, r_rsp_a, r_rsp_b;

  // Counter is held at zero outside CLEAR so every sweep starts at address 0.
  ram_sweep_counter #(.ADDR_W(ADDR_W)) u_sweep (
    .clk     (clk),
    .rst_n   (reset),
    .i_clr   (r_state != CLEAR),
    .i_en    (r_state == CLEAR),
    .o_count (w_count),
    .o_last  (w_last)
  );

  assign req_ready = (r_state == IDLE) && !clr_req;
  assign w_accept  = req_valid && req_ready;
  assign busy      = (r_state == CLEAR);
  assign rsp_valid = (r_state == RESP);
  assign ram_wr    = (r_state == CLEAR) || (r_state == WRITE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= RST_WAIT;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      RST_WAIT: w_next = CLEAR;
      CLEAR:    if (w_last) w_next = IDLE;
      IDLE: begin
        if (clr_req)        w_next = CLEAR;
        else if (req_valid) w_next = req_wr ? WRITE : READ;
      end
      WRITE:    w_next = IDLE;
      READ:     w_next = RESP;
      RESP:     if (rsp_ready) w_next = IDLE;
      default:  w_next = RST_WAIT;
    endcase
  end

  // Address/data registers double as the "hold last driven value" storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_addr   <= '0;
      r_wdata     <= '0;
      r_rd_addr_a <= '0;
      r_rd_addr_b <= '0;
      r_rsp_a     <= '0;
      r_rsp_b     <= '0;
    end else begin
      if (r_state == CLEAR) begin
        r_wr_addr <= w_count;
        r_wdata   <= FILL_VALUE;
      end
      if (w_accept) begin
        if (req_wr) begin
          r_wr_addr <= req_addr_a;
          r_wdata   <= req_wdata;
        end else begin
          r_rd_addr_a <= req_addr_a;
          r_rd_addr_b <= req_addr_b;
        end
      end
      if (r_state == READ) begin
        r_rsp_a <= ram_d_out_a;
        r_rsp_b <= ram_d_out_b;
      end
    end
  end

  assign ram_wr_addr   = (r_state == CLEAR) ? w_count    : r_wr_addr;
  assign ram_d_in      = (r_state == CLEAR) ? FILL_VALUE : r_wdata;
  assign ram_rd_addr_a = r_rd_addr_a;
  assign ram_rd_addr_b = r_rd_addr_b;
  assign rsp_data_a    = r_rsp_a;
  assign rsp_data_b    = r_rsp_b;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl with a 4-word behavioural RAM and an
// abstract memory-contents reference model.
module tb_ram_access_ctrl;

  localparam int AW = 2;
  localparam int DW = 16;

  logic          clk, reset;
  logic          req_valid, req_ready, req_wr;
  logic [AW-1:0] req_addr_a, req_addr_b;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data_a, rsp_data_b;
  logic          clr_req, busy, ram_wr;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr_a, ram_rd_addr_b;
  logic [DW-1:0] ram_d_in, ram_d_out_a, ram_d_out_b;

  ram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .FILL_VALUE(16'h0000)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr_a(req_addr_a), .req_addr_b(req_addr_b), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b),
    .clr_req(clr_req), .busy(busy),
    .ram_wr(ram_wr), .ram_wr_addr(ram_wr_addr), .ram_d_in(ram_d_in),
    .ram_rd_addr_a(ram_rd_addr_a), .ram_rd_addr_b(ram_rd_addr_b),
    .ram_d_out_a(ram_d_out_a), .ram_d_out_b(ram_d_out_b)
  );

  // Behavioural RAM: synchronous write, combinational read.
  logic [DW-1:0] mem [4];
  always @(posedge clk) if (ram_wr) mem[ram_wr_addr] <= ram_d_in;
  assign ram_d_out_a = mem[ram_rd_addr_a];
  assign ram_d_out_b = mem[ram_rd_addr_b];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int wr_pulses = 0;
  always @(negedge clk) if (ram_wr === 1'b1) wr_pulses <= wr_pulses + 1;

  int n_chk = 0, n_pass = 0;
  logic [DW-1:0] ref_mem [4];

  typedef struct {
    bit            wr;
    logic [AW-1:0] a, b;
    logic [DW-1:0] wd, ea, eb;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic ref_fill();
    for (int i = 0; i < 4; i++) ref_mem[i] = 16'h0000;
  endtask

  // Observes the RST_WAIT + 4-cycle sweep that follows reset release.
  task automatic check_sweep(input string tag);
    int nw = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk({tag, "_ready"}, req_ready, 32'(c == 5));
      chk({tag, "_ramwr"}, ram_wr, 32'(c >= 1 && c <= 4));
      chk({tag, "_busy"}, busy, 32'(c >= 1 && c <= 4));
      if (ram_wr) begin
        chk({tag, "_addr"}, ram_wr_addr, c - 1);
        chk({tag, "_fill"}, ram_d_in, 0);
        nw++;
      end
    end
    chk({tag, "_nwrites"}, nw, 4);
    ref_fill();
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("wait_idle", req_ready, 1);
  endtask

  // Presents a request and returns just after the accepting edge.
  task automatic send(input bit wr, input logic [AW-1:0] a, b, input logic [DW-1:0] wd);
    int n = 0;
    req_valid = 1'b1; req_wr = wr; req_addr_a = a; req_addr_b = b; req_wdata = wd;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("accept", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr_a = 'x; req_addr_b = 'x; req_wdata = 'x;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    send(1'b1, a, 0, d);
    @(negedge clk);
    chk("wr_en", ram_wr, 1);
    chk("wr_addr", ram_wr_addr, a);
    chk("wr_data", ram_d_in, d);
    chk("wr_ready_low", req_ready, 0);
    ref_mem[a] = d;
  endtask

  task automatic do_read(input logic [AW-1:0] a, b, output logic [DW-1:0] da, db);
    int lat = 0;
    da = 'x; db = 'x;
    send(1'b0, a, b, 0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk("rd_addr_a", ram_rd_addr_a, a);
        chk("rd_addr_b", ram_rd_addr_b, b);
      end
      if (rsp_valid) begin lat = i; da = rsp_data_a; db = rsp_data_b; break; end
    end
    chk("rd_latency", lat, 2);
    @(posedge clk); #1;
  endtask

  task automatic read_ref(input logic [AW-1:0] a, b);
    logic [DW-1:0] da, db;
    do_read(a, b, da, db);
    chk("rd_data_a", da, ref_mem[a]);
    chk("rd_data_b", db, ref_mem[b]);
  endtask

  task automatic do_clear();
    int nb = 0;
    wait_idle();
    clr_req = 1'b1;
    @(posedge clk); #1;
    clr_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy) nb++;
    end
    chk("clr_busy_cycles", nb, 4);
    ref_fill();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vt[$];
    logic [DW-1:0] da, db;
    int acc [4];
    int wbase, nb, n;
    bit saw_ffff;

    vt.push_back('{0, 2'd0, 2'd3, 16'h0000, 16'h0000, 16'h0000});
    vt.push_back('{1, 2'd3, 2'd0, 16'hABCD, 16'h0000, 16'h0000});
    vt.push_back('{0, 2'd3, 2'd3, 16'h0000, 16'hABCD, 16'hABCD});
    vt.push_back('{1, 2'd1, 2'd0, 16'h0F0F, 16'h0000, 16'h0000});
    vt.push_back('{0, 2'd1, 2'd3, 16'h0000, 16'h0F0F, 16'hABCD});
    vt.push_back('{0, 2'd0, 2'd2, 16'h0000, 16'h0000, 16'h0000});
    vt.push_back('{1, 2'd0, 2'd0, 16'h1111, 16'h0000, 16'h0000});
    vt.push_back('{0, 2'd0, 2'd1, 16'h0000, 16'h1111, 16'h0F0F});

    reset = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr_a = '0; req_addr_b = '0;
    req_wdata = '0; rsp_ready = 1'b1; clr_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_ramwr", ram_wr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rspvalid", rsp_valid, 0);
    chk("rst_wraddr", ram_wr_addr, 0);
    chk("rst_din", ram_d_in, 0);
    chk("rst_rdaddr", {ram_rd_addr_a, ram_rd_addr_b}, 0);
    chk("rst_rspdata", {rsp_data_a, rsp_data_b}, 0);
    @(posedge clk); #1 reset = 1'b1;
    check_sweep("init");

    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].wr) do_write(vt[i].a, vt[i].wd);
      else begin
        do_read(vt[i].a, vt[i].b, da, db);
        chk("vec_a", da, vt[i].ea);
        chk("vec_b", db, vt[i].eb);
      end
    end

    // Response held under back-pressure.
    do_write(2'd0, 16'h1234);
    do_write(2'd1, 16'h5678);
    rsp_ready = 1'b0;
    send(1'b0, 2'd0, 2'd1, 0);
    @(negedge clk);
    chk("bp_valid_early", rsp_valid, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data_a", rsp_data_a, 16'h1234);
      chk("bp_data_b", rsp_data_b, 16'h5678);
      chk("bp_ready_low", req_ready, 0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_hs", rsp_valid, 1);
    chk("bp_ready_hs", req_ready, 0);
    @(negedge clk);
    chk("bp_ready_back", req_ready, 1);
    chk("bp_valid_gone", rsp_valid, 0);

    // Clear collides with a write: clear wins, write dropped.
    do_write(2'd2, 16'h5555);
    wait_idle();
    clr_req = 1'b1; req_valid = 1'b1; req_wr = 1'b1; req_addr_a = 2'd2; req_wdata = 16'hFFFF;
    #1 chk("clr_blocks_ready", req_ready, 0);
    @(posedge clk); #1;
    clr_req = 1'b0; req_valid = 1'b0;
    nb = 0; saw_ffff = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (ram_wr && ram_d_in == 16'hFFFF) saw_ffff = 1'b1;
    end
    chk("clrwr_busy_cycles", nb, 4);
    chk("clrwr_no_write", saw_ffff, 0);
    ref_fill();
    read_ref(2'd2, 2'd3);

    // Reset in the middle of a sweep.
    do_write(2'd1, 16'h7777);
    wait_idle();
    clr_req = 1'b1;
    @(posedge clk); #1 clr_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_addr2", ram_wr_addr, 2);
    chk("mid_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk("mid_ramwr_drop", ram_wr, 0);
    chk("mid_busy_drop", busy, 0);
    chk("mid_addr_zero", ram_wr_addr, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    check_sweep("mid");
    read_ref(2'd1, 2'd2);

    // Back-to-back writes with req_valid held high.
    wait_idle();
    wbase = wr_pulses;
    req_valid = 1'b1; req_wr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_addr_a = AW'(3 - k); req_wdata = 16'hC000 + 16'(k);
      if (k > 0) @(negedge clk);
      n = 0;
      while (!req_ready && n < 10) begin @(negedge clk); n++; end
      chk("b2b_accept", req_ready, 1);
      acc[k] = cyc;
      ref_mem[3 - k] = 16'hC000 + 16'(k);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    for (int k = 1; k < 4; k++) chk("b2b_spacing", acc[k] - acc[k-1], 2);
    @(negedge clk); @(negedge clk); #1;
    chk("b2b_write_count", wr_pulses - wbase, 4);
    read_ref(2'd0, 2'd3);
    read_ref(2'd1, 2'd2);

    // Randomised traffic against the contents model.
    for (int i = 0; i < 150; i++) begin
      n = $urandom_range(0, 19);
      if (n == 0) do_clear();
      else if (n < 10) do_write(AW'($urandom_range(0, 3)), 16'($urandom));
      else read_ref(AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
